// File: rtl/blink_interval_timer.sv
`default_nettype none
// ============================================================================
// Module  : blink_interval_timer
// Purpose : Measures N time units (PRESCALE clocks each) on request from the
//           LED blinking state machine and returns a one-cycle enable pulse.
// Rev     : 1.0  initial release
// ============================================================================
module blink_interval_timer #(
  parameter int PRESCALE = 50_000_000,
  parameter int PS_W     = $clog2(PRESCALE)
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_flag_counter,
  input  logic [2:0] i_count_ena,
  output logic       o_enable,
  output logic       o_busy,
  output logic       o_tick,
  output logic [2:0] o_elapsed
);

  localparam logic [1:0]      c_IDLE    = 2'd0;
  localparam logic [1:0]      c_COUNT   = 2'd1;
  localparam logic [1:0]      c_DONE    = 2'd2;
  localparam logic [PS_W-1:0] c_PS_LAST = PS_W'(PRESCALE - 1);

  logic [1:0]      r_state;
  logic [1:0]      w_next_state;
  logic [PS_W-1:0] r_ps;
  logic [2:0]      r_unit;
  logic [2:0]      r_prev_ena;
  logic            r_was_count;
  logic            r_enable;
  logic            r_busy;
  logic            r_tick;

  logic            w_req;
  logic            w_wrap;
  logic            w_terminal;
  logic            w_restart;
  logic            w_enable_d;
  logic            w_busy_d;
  logic            w_tick_d;

  assign w_req      = i_flag_counter && (i_count_ena != 3'd0);
  assign w_wrap     = (r_ps == c_PS_LAST);
  assign w_terminal = w_wrap && (r_unit == (i_count_ena - 3'd1));
  // The first COUNT cycle has r_was_count low, so a length change made right
  // after a pulse does not restart the interval.
  assign w_restart  = r_was_count && (i_count_ena != r_prev_ena);

  // State register and registered outputs
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state     <= c_IDLE;
      r_was_count <= 1'b0;
      r_enable    <= 1'b0;
      r_busy      <= 1'b0;
      r_tick      <= 1'b0;
    end else begin
      r_state     <= w_next_state;
      r_was_count <= (r_state == c_COUNT);
      r_enable    <= w_enable_d;
      r_busy      <= w_busy_d;
      r_tick      <= w_tick_d;
    end
  end

  // Next-state logic: flag drop / zero request beats restart, restart beats terminal
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      c_IDLE:  if (w_req) w_next_state = c_COUNT;
      c_COUNT: begin
        if (!w_req)          w_next_state = c_IDLE;
        else if (w_restart)  w_next_state = c_COUNT;
        else if (w_terminal) w_next_state = c_DONE;
        else                 w_next_state = c_COUNT;
      end
      c_DONE:  w_next_state = w_req ? c_COUNT : c_IDLE;
      default: w_next_state = c_IDLE;
    endcase
  end

  // Output decode, registered in the state process
  always_comb begin
    w_enable_d = (w_next_state == c_DONE);
    w_busy_d   = (w_next_state == c_COUNT);
    w_tick_d   = (r_state == c_COUNT) && w_req && !w_restart && w_wrap;
  end

  // Prescaler and unit counter
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_ps       <= '0;
      r_unit     <= 3'd0;
      r_prev_ena <= 3'd0;
    end else begin
      r_prev_ena <= (r_state == c_IDLE) ? 3'd0 : i_count_ena;
      if ((r_state == c_COUNT) && (w_next_state == c_COUNT) && !w_restart) begin
        if (w_wrap) begin
          r_ps   <= '0;
          r_unit <= r_unit + 3'd1;
        end else begin
          r_ps   <= r_ps + PS_W'(1);
        end
      end else begin
        r_ps   <= '0;
        r_unit <= 3'd0;
      end
    end
  end

  assign o_enable  = r_enable;
  assign o_busy    = r_busy;
  assign o_tick    = r_tick;
  assign o_elapsed = r_unit;

endmodule
`default_nettype wire

// File: tb/tb_blink_interval_timer.sv
`default_nettype none
// ============================================================================
// Module  : tb_blink_interval_timer
// Purpose : Directed, scoreboard-checked bench for blink_interval_timer.
// Rev     : 1.0  initial release
// ============================================================================
module tb_blink_interval_timer;

  localparam int c_PRESCALE = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       flag;
  logic [2:0] ena;
  logic       o_enable;
  logic       o_busy;
  logic       o_tick;
  logic [2:0] o_elapsed;

  int cyc       = 0;
  int n_cmp     = 0;
  int n_err     = 0;
  int tick_cnt  = 0;
  int max_el    = 0;
  bit busy_seen = 1'b0;
  int exp_q[$];

  blink_interval_timer #(.PRESCALE(c_PRESCALE)) dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_flag_counter (flag),
    .i_count_ena    (ena),
    .o_enable       (o_enable),
    .o_busy         (o_busy),
    .o_tick         (o_tick),
    .o_elapsed      (o_elapsed)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic goto(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  // Pulse monitor: every enable pulse is matched against the expected cycle queue
  always @(negedge clk) begin
    int exp_c;
    if (o_tick === 1'b1) tick_cnt++;
    if (o_busy === 1'b1) busy_seen = 1'b1;
    if (int'(o_elapsed) > max_el) max_el = int'(o_elapsed);
    if (o_enable === 1'b1) begin
      if (exp_q.size() == 0) exp_c = -1;
      else                   exp_c = exp_q.pop_front();
      n_cmp++;
      assert (cyc === exp_c) else begin
        n_err++;
        $error("FAIL pulse_time: observed cycle %0d expected cycle %0d", cyc, exp_c);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int e0, p, n;
    rst = 1'b1; flag = 1'b0; ena = 3'd0;
    repeat (2) @(negedge clk);
    check("reset_enable",  o_enable,  0);
    check("reset_busy",    o_busy,    0);
    check("reset_tick",    o_tick,    0);
    check("reset_elapsed", o_elapsed, 0);
    rst = 1'b0;
    @(negedge clk);

    // Single interval of 6 units
    tick_cnt = 0; max_el = 0;
    flag = 1'b1; ena = 3'd6; e0 = cyc + 1; exp_q.push_back(e0 + 24);
    goto(e0);      check("entry_busy", o_busy, 1);
    goto(e0 + 12); check("single_elapsed3", o_elapsed, 3);
    goto(e0 + 24); check("single_enable", o_enable, 1);
    flag = 1'b0;
    goto(e0 + 25); check("single_enable_width", o_enable, 0);
    check("single_pending", exp_q.size(), 0);
    goto(e0 + 30);
    check("single_ticks", tick_cnt, 6);
    check("single_max_elapsed", max_el, 5);
    check("single_idle_busy", o_busy, 0);

    // Blink chain 6,4,6,4,6,4; length changes in the first cycle after a pulse
    flag = 1'b1; ena = 3'd6; p = cyc + 1 + 24; exp_q.push_back(p);
    for (int k = 1; k <= 6; k++) begin
      goto(p);
      if (k == 6) flag = 1'b0;
      goto(p + 1);
      check($sformatf("chain_pending%0d", k), exp_q.size(), 0);
      if (k < 6) begin
        n = (k % 2 == 1) ? 4 : 6;
        ena = 3'(n);
        p = p + 1 + n * c_PRESCALE;
        exp_q.push_back(p);
      end
    end
    check("chain_idle_busy", o_busy, 0);

    // Flag drop mid-interval
    flag = 1'b1; ena = 3'd6; e0 = cyc + 1;
    goto(e0 + 8); check("drop_elapsed2", o_elapsed, 2);
    flag = 1'b0;
    goto(e0 + 9);
    check("drop_busy", o_busy, 0);
    check("drop_elapsed", o_elapsed, 0);
    goto(e0 + 40);
    flag = 1'b1; ena = 3'd4; e0 = cyc + 1; exp_q.push_back(e0 + 16);
    goto(e0 + 16); flag = 1'b0;
    goto(e0 + 17); check("drop_retry_pending", exp_q.size(), 0);

    // Mid-interval length change restarts the count
    flag = 1'b1; ena = 3'd6; e0 = cyc + 1;
    goto(e0 + 12); check("change_elapsed3", o_elapsed, 3);
    ena = 3'd4; exp_q.push_back(e0 + 13 + 16);
    goto(e0 + 13);
    check("change_elapsed0", o_elapsed, 0);
    check("change_busy", o_busy, 1);
    goto(e0 + 29); flag = 1'b0;
    goto(e0 + 30); check("change_pending", exp_q.size(), 0);

    // Zero request stays idle
    busy_seen = 1'b0; flag = 1'b1; ena = 3'd0;
    repeat (100) @(negedge clk);
    check("zero_busy_seen", busy_seen, 0);
    ena = 3'd2; e0 = cyc + 1; exp_q.push_back(e0 + 8);
    goto(e0 + 8); flag = 1'b0;
    goto(e0 + 9); check("zero_retry_pending", exp_q.size(), 0);

    // Asynchronous reset mid-interval
    flag = 1'b1; ena = 3'd6; e0 = cyc + 1;
    goto(e0 + 12); check("rstmid_elapsed3", o_elapsed, 3);
    #1 rst = 1'b1;
    #1;
    check("rstmid_enable",  o_enable,  0);
    check("rstmid_busy",    o_busy,    0);
    check("rstmid_tick",    o_tick,    0);
    check("rstmid_elapsed", o_elapsed, 0);
    @(negedge clk);
    rst = 1'b0; e0 = cyc + 1; exp_q.push_back(e0 + 24);
    goto(e0 + 24); flag = 1'b0;
    goto(e0 + 25); check("rstmid_pending", exp_q.size(), 0);

    repeat (10) @(negedge clk);
    check("final_pending", exp_q.size(), 0);
    check("final_busy", o_busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
